// File: rtl/regfile_sb_if.sv
// Register file access bundle: read ports, write port, issue port.
// Master drives indices and data, slave returns read data and scoreboard.
interface regfile_sb_if #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
);
  logic [NREAD*AW-1:0]   rs;
  logic [NREAD*XLEN-1:0] rdata;
  logic [NREAD-1:0]      rbusy;
  logic                  we;
  logic [AW-1:0]         rd;
  logic [XLEN-1:0]       wdata;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rd;
  logic [NREGS-1:0]      busy_vec;

  modport master (
    output rs, we, rd, wdata,
    output iss_valid, iss_rd,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  rs, we, rd, wdata,
    input  iss_valid, iss_rd,
    output rdata, rbusy, busy_vec
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass and busy scoreboard.
// x0 reads as zero and is never busy; reset clears data and scoreboard.
module regfile_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NREAD  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic clk,
  input  logic rst_n,
  regfile_sb_if.slave bus
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;

  logic [NREAD-1:0][AW-1:0]   rs_c;
  logic [NREAD-1:0][XLEN-1:0] rdata_c;
  logic [NREAD-1:0]           rbusy_c;
  logic [NREAD-1:0]           zero_c;
  logic [NREAD-1:0]           byp_c;

  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = bus.we && (bus.rd != '0);
  assign iss_ok = bus.iss_valid && (bus.iss_rd != '0);

  // Next register contents: single write port, x0 untouched.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[bus.rd] = bus.wdata;
    end
  end

  // Next scoreboard: write clears, issue sets and wins on a tie.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[bus.rd] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State update; reset discards any same-cycle write or issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign rs_c = bus.rs;

  // Per-port select terms; bypass ignores rst_n and the issue port.
  always_comb begin
    zero_c = '0;
    byp_c  = '0;
    for (int i = 0; i < NREAD; i++) begin
      zero_c[i] = (rs_c[i] == '0);
      byp_c[i]  = (BYPASS != 0) && !zero_c[i] &&
                  bus.we && (bus.rd == rs_c[i]);
    end
  end

  // Read mux: zero, forwarded write, or stored value.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int i = 0; i < NREAD; i++) begin
      unique case (1'b1)
        zero_c[i]: begin
          rdata_c[i] = '0;
          rbusy_c[i] = 1'b0;
        end
        byp_c[i]: begin
          rdata_c[i] = bus.wdata;
          rbusy_c[i] = 1'b0;
        end
        default: begin
          rdata_c[i] = regs_q[rs_c[i]];
          rbusy_c[i] = busy_q[rs_c[i]];
        end
      endcase
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.rbusy    = rbusy_c;
  assign bus.busy_vec = busy_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the RV32I core and its pipelined successors. It has NREAD combinational read ports, one write port and write-to-read bypass. A per-register busy scoreboard supports hazard detection in a pipelined datapath. Register 0 is hardwired to zero and is never busy. The register array and scoreboard are both cleared by reset.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers; power of two, at least 2
AW, $clog2(NREGS), register index width (derived; not to be overridden)
NREAD, 2, number of independent read ports, 1..4
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored contents only

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
rs  in  NREAD*AW  read indices; port i uses bits [i*AW +: AW]
rdata  out  NREAD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
rbusy  out  NREAD  port i: the source register has a pending, not yet written, result
we  in  1  write enable
rd  in  AW  write index
wdata  in  XLEN  write data
iss_valid  in  1  issue of an instruction that will later write iss_rd
iss_rd  in  AW  destination index being issued
busy_vec  out  NREGS  full scoreboard, bit n = register n busy (for debug and stall logic)

Behaviour:
- Reset: clock edge with rst_n=0 clears all NREGS registers to 0 and all busy bits to 0. In that cycle, we and iss_valid are ignored. After reset, every rdata = 0, rbusy = 0 and busy_vec = 0. A reset asserted mid-operation discards pending writes and issues with no partial update.
- Write: at posedge, if rst_n=1, we=1 and rd!=0, then reg[rd] <= wdata and busy[rd] <= 0. A write with rd=0 has no effect.
- Issue: at posedge, if rst_n=1, iss_valid=1 and iss_rd!=0, then busy[iss_rd] <= 1. An issue with iss_rd=0 has no effect.
- Simultaneous write and issue to the same rd != 0: the data is written and busy ends at 1, because the new issue wins. Different indices update independently.
- Read (combinational, zero latency), per port i with index s = rs[i]:
  - s=0: rdata=0, rbusy=0.
  - BYPASS=1, we=1 and rd==s: rdata=wdata and rbusy=0.
  - Otherwise: rdata=reg[s] and rbusy=busy[s].
- A same-cycle issue never affects same-cycle read outputs.
- Bypass is not gated by rst_n; reset dominates only the stored state.
- busy_vec is the registered scoreboard with no bypass; bit 0 is constantly 0.
- Multiple read ports may address the same register; each returns identical results.
- No X propagation: after reset, every register is readable.
- Read paths are combinational only from rs, we, rd and wdata (no path from iss_*).

Test Plan:
- Reset then read: pre-load garbage, hold rst_n=0 for one edge, read rs0=5, rs1=31 -> rdata 0/0, rbusy 0/0, busy_vec=0.
- Write/read and x0: write rd=3, wdata=0xDEADBEEF, then rd=0, wdata=0x1234. Next cycle read rs0=3, rs1=0 -> 0xDEADBEEF, 0x00000000.
- Bypass: with reg[7]=0x11, in the same cycle assert we, rd=7, wdata=0x22 and rs0=7 -> rdata0=0x22, rbusy0=0 in that cycle. With BYPASS=0 -> rdata0=0x11, then 0x22 on the next cycle.
- Scoreboard lifecycle: issue iss_rd=9 -> next cycle rbusy=1 and busy_vec[9]=1 on rs=9. Write rd=9 -> rbusy=0 in the write cycle (bypass); busy_vec[9]=0 on the next cycle.
- Simultaneous write and issue: busy[4]=1, then in one cycle we rd=4, wdata=0x55 plus iss_valid iss_rd=4 -> next cycle reg[4]=0x55 and busy[4]=1. Issue or write to rd=0 -> busy_vec[0] stays 0.
- Mid-operation reset: set busy on 2 and 6, write reg[6]=0xAB, then rst_n=0 in a cycle that also has we rd=2 and iss_valid iss_rd=8 -> after the edge all registers are 0, busy_vec=0 and reg[2]=0. Repeat with NREAD=4 and NREGS=16 for parameter coverage.
